// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types and helpers for the paddle array
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_F,
    CMD_B
  } cmd_t;

  // Highest legal position: the paddle must still fit inside the playfield.
  function automatic int top_max(input int pos_max, input int paddle_length);
    return pos_max - paddle_length;
  endfunction

  function automatic cmd_t decode_cmd(input logic fwd, input logic bwd);
    cmd_t cmd;
    cmd = CMD_NONE;
    if (fwd && !bwd) cmd = CMD_F;
    else if (bwd && !fwd) cmd = CMD_B;
    return cmd;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// rtl/paddle_channel.sv - one paddle: direction FSM, speed ramp, position and clamp
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int POS_WIDTH     = 12,
  parameter int PADDLE_LENGTH = 200,
  parameter int POS_MIN       = 0,
  parameter int POS_MAX       = 479,
  parameter int START_POS     = 140,
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_MAX     = 16,
  parameter int ACCEL         = 2,
  parameter int SPEED_WIDTH   = 6
) (
  input  logic                 pixel_clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 move_forward,
  input  logic                 move_backward,
  output logic [POS_WIDTH-1:0] paddle_pos,
  output logic                 paddle_moving,
  output logic                 at_min,
  output logic                 at_max
);

  localparam int TOP_MAX = top_max(POS_MAX, PADDLE_LENGTH);

  localparam logic [POS_WIDTH:0]     TOP_W       = (POS_WIDTH+1)'(TOP_MAX);
  localparam logic [POS_WIDTH:0]     MIN_W       = (POS_WIDTH+1)'(POS_MIN);
  localparam logic [POS_WIDTH-1:0]   TOP_P       = POS_WIDTH'(TOP_MAX);
  localparam logic [POS_WIDTH-1:0]   MIN_P       = POS_WIDTH'(POS_MIN);
  localparam logic [POS_WIDTH-1:0]   START_P     = POS_WIDTH'(START_POS);
  localparam logic [SPEED_WIDTH-1:0] SPEED_MIN_S = SPEED_WIDTH'(SPEED_MIN);
  localparam logic [SPEED_WIDTH-1:0] SPEED_MAX_S = SPEED_WIDTH'(SPEED_MAX);
  localparam logic [SPEED_WIDTH:0]   SPEED_MAX_E = (SPEED_WIDTH+1)'(SPEED_MAX);
  localparam logic [SPEED_WIDTH:0]   ACCEL_E     = (SPEED_WIDTH+1)'(ACCEL);

  state_t                 state, state_next;
  cmd_t                   cmd;
  logic [SPEED_WIDTH-1:0] speed, speed_next, speed_up;
  logic [SPEED_WIDTH:0]   speed_sum;
  logic [POS_WIDTH-1:0]   pos, pos_next;
  logic [POS_WIDTH:0]     step, fwd_sum, bwd_floor;

  always_comb begin
    state_next = state;
    speed_next = speed;
    pos_next   = pos;
    cmd        = decode_cmd(move_forward, move_backward);
    speed_sum  = {1'b0, speed} + ACCEL_E;
    speed_up   = SPEED_MIN_S;
    // Only a continued push in the same direction accelerates; any other start is slow.
    if ((cmd == CMD_F && state == FWD) || (cmd == CMD_B && state == BWD))
      speed_up = (speed_sum > SPEED_MAX_E) ? SPEED_MAX_S : speed_sum[SPEED_WIDTH-1:0];
    step      = (POS_WIDTH+1)'(speed_up);
    fwd_sum   = {1'b0, pos} + step;
    bwd_floor = MIN_W + step;

    if (tick) begin
      case (cmd)
        CMD_F: begin
          state_next = FWD;
          if (fwd_sum > TOP_W) begin
            pos_next   = TOP_P;
            speed_next = SPEED_MIN_S;
          end else begin
            pos_next   = fwd_sum[POS_WIDTH-1:0];
            speed_next = speed_up;
          end
        end
        CMD_B: begin
          state_next = BWD;
          if ({1'b0, pos} < bwd_floor) begin
            pos_next   = MIN_P;
            speed_next = SPEED_MIN_S;
          end else begin
            pos_next   = pos - step[POS_WIDTH-1:0];
            speed_next = speed_up;
          end
        end
        default: begin
          state_next = IDLE;
          speed_next = '0;
        end
      endcase
    end
  end

  // Status flags are registered from the next-state values so they line up with paddle_pos.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state         <= IDLE;
      speed         <= '0;
      pos           <= START_P;
      paddle_moving <= 1'b0;
      at_min        <= (START_P == MIN_P);
      at_max        <= (START_P == TOP_P);
    end else begin
      state         <= state_next;
      speed         <= speed_next;
      pos           <= pos_next;
      paddle_moving <= (state_next != IDLE);
      at_min        <= (pos_next == MIN_P);
      at_max        <= (pos_next == TOP_P);
    end
  end

  assign paddle_pos = pos;

endmodule

// File: rtl/paddle_array.sv
// rtl/paddle_array.sv - N independent paddles updated once per frame on vsync rise
module paddle_array
  import paddle_pkg::*;
#(
  parameter int NUM_PADDLES   = 2,
  parameter int POS_WIDTH     = 12,
  parameter int PADDLE_LENGTH = 200,
  parameter int POS_MIN       = 0,
  parameter int POS_MAX       = 479,
  parameter int START_POS     = 140,
  parameter int SPEED_MIN     = 2,
  parameter int SPEED_MAX     = 16,
  parameter int ACCEL         = 2,
  parameter int SPEED_WIDTH   = 6
) (
  input  logic                             pixel_clock,
  input  logic                             reset,
  input  logic                             vertical_sync,
  input  logic [NUM_PADDLES-1:0]           move_forward,
  input  logic [NUM_PADDLES-1:0]           move_backward,
  output logic [NUM_PADDLES*POS_WIDTH-1:0] paddle_pos,
  output logic [NUM_PADDLES-1:0]           paddle_moving,
  output logic [NUM_PADDLES-1:0]           at_min,
  output logic [NUM_PADDLES-1:0]           at_max,
  output logic                             frame_tick
);

  localparam int TOP_MAX = top_max(POS_MAX, PADDLE_LENGTH);

  if (NUM_PADDLES < 1) begin : g_err_count
    $error("paddle_array: NUM_PADDLES must be at least 1");
  end
  if (SPEED_MIN > SPEED_MAX || SPEED_MAX >= 2**SPEED_WIDTH) begin : g_err_speed
    $error("paddle_array: speed range does not fit SPEED_WIDTH");
  end
  if (POS_MIN > START_POS || START_POS > TOP_MAX) begin : g_err_start
    $error("paddle_array: START_POS outside legal range");
  end
  if (POS_MAX >= 2**POS_WIDTH) begin : g_err_width
    $error("paddle_array: POS_MAX does not fit POS_WIDTH");
  end

  logic last_vsync;

  // last_vsync resets high so a vsync already asserted at release is not a new frame.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      last_vsync <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      last_vsync <= vertical_sync;
      frame_tick <= vertical_sync && !last_vsync;
    end
  end

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_channel
    paddle_channel #(
      .POS_WIDTH     (POS_WIDTH),
      .PADDLE_LENGTH (PADDLE_LENGTH),
      .POS_MIN       (POS_MIN),
      .POS_MAX       (POS_MAX),
      .START_POS     (START_POS),
      .SPEED_MIN     (SPEED_MIN),
      .SPEED_MAX     (SPEED_MAX),
      .ACCEL         (ACCEL),
      .SPEED_WIDTH   (SPEED_WIDTH)
    ) u_channel (
      .pixel_clock   (pixel_clock),
      .reset         (reset),
      .tick          (frame_tick),
      .move_forward  (move_forward[i]),
      .move_backward (move_backward[i]),
      .paddle_pos    (paddle_pos[i*POS_WIDTH +: POS_WIDTH]),
      .paddle_moving (paddle_moving[i]),
      .at_min        (at_min[i]),
      .at_max        (at_max[i])
    );
  end

endmodule

// File: tb/tb_paddle_array.sv
// tb/tb_paddle_array.sv - scoreboard bench for the two-channel paddle array
module tb_paddle_array;

  localparam int TOP = 279;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic        vertical_sync;
  logic [1:0]  move_forward;
  logic [1:0]  move_backward;
  logic [23:0] paddle_pos;
  logic [1:0]  paddle_moving;
  logic [1:0]  at_min;
  logic [1:0]  at_max;
  logic        frame_tick;

  paddle_array dut (
    .pixel_clock   (pixel_clock),
    .reset         (reset),
    .vertical_sync (vertical_sync),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .paddle_pos    (paddle_pos),
    .paddle_moving (paddle_moving),
    .at_min        (at_min),
    .at_max        (at_max),
    .frame_tick    (frame_tick)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    int         p0;
    int         p1;
    logic [1:0] mv;
    logic [1:0] amin;
    logic [1:0] amax;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_idx = 0;
  bit   pend = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a tick seen at one falling edge means the update is visible at the next one.
  always @(negedge pixel_clock) begin
    if (pend) begin
      if (sb.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        tick_idx++;
        chk($sformatf("tick%0d pos0", tick_idx), int'(paddle_pos[11:0]), mon_e.p0);
        chk($sformatf("tick%0d pos1", tick_idx), int'(paddle_pos[23:12]), mon_e.p1);
        chk($sformatf("tick%0d moving", tick_idx), int'(paddle_moving), int'(mon_e.mv));
        chk($sformatf("tick%0d at_min", tick_idx), int'(at_min), int'(mon_e.amin));
        chk($sformatf("tick%0d at_max", tick_idx), int'(at_max), int'(mon_e.amax));
      end
    end
    pend = frame_tick;
  end

  task automatic push_exp(input int e0, input int e1, input logic [1:0] mv);
    exp_t e;
    e.p0   = e0;
    e.p1   = e1;
    e.mv   = mv;
    e.amin = {e1 == 0, e0 == 0};
    e.amax = {e1 == TOP, e0 == TOP};
    sb.push_back(e);
  endtask

  task automatic do_tick(input logic [1:0] f, input logic [1:0] b, input int e0, input int e1);
    push_exp(e0, e1, f ^ b);
    move_forward  = f;
    move_backward = b;
    @(negedge pixel_clock) vertical_sync = 1'b1;
    repeat (3) @(negedge pixel_clock);
    vertical_sync = 1'b0;
    repeat (3) @(negedge pixel_clock);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " pos0"}, int'(paddle_pos[11:0]), 140);
    chk({tag, " pos1"}, int'(paddle_pos[23:12]), 140);
    chk({tag, " moving"}, int'(paddle_moving), 0);
    chk({tag, " at_min"}, int'(at_min), 0);
    chk({tag, " at_max"}, int'(at_max), 0);
  endtask

  task automatic do_reset();
    @(negedge pixel_clock) reset = 1'b1;
    repeat (2) @(negedge pixel_clock);
    check_reset_state("mid_reset");
    reset = 1'b0;
    @(negedge pixel_clock);
  endtask

  int fwd13[13] = '{142, 146, 152, 160, 170, 182, 196, 212, 228, 244, 260, 276, 279};
  int bwd20[20] = '{277, 273, 267, 259, 249, 237, 223, 207, 191, 175,
                    159, 143, 127, 111, 95, 79, 63, 47, 31, 15};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    vertical_sync = 1'b0;
    move_forward  = 2'b00;
    move_backward = 2'b00;

    // Reset held while vsync toggles: no ticks, start positions.
    for (int i = 0; i < 8; i++) begin
      @(negedge pixel_clock);
      vertical_sync = ~vertical_sync;
      chk("tick_in_reset", int'(frame_tick), 0);
    end
    check_reset_state("reset");

    // Release with vsync already high must not create a frame.
    @(negedge pixel_clock) vertical_sync = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pixel_clock);
      chk("tick_after_release", int'(frame_tick), 0);
    end
    vertical_sync = 1'b0;
    repeat (2) @(negedge pixel_clock);

    // Ch0 forward ramp, ch1 idle; then reversal and both-pressed.
    do_tick(2'b01, 2'b00, 142, 140);
    do_tick(2'b01, 2'b00, 146, 140);
    do_tick(2'b01, 2'b00, 152, 140);
    do_tick(2'b01, 2'b00, 160, 140);
    do_tick(2'b00, 2'b01, 158, 140);
    do_tick(2'b01, 2'b01, 158, 140);

    // Long forward run to the top clamp on both channels, then ch1 releases.
    do_reset();
    for (int i = 0; i < 13; i++) do_tick(2'b11, 2'b00, fwd13[i], fwd13[i]);
    do_tick(2'b01, 2'b00, TOP, TOP);

    // Ch1 walks down to 3, then from rest clamps at the bottom.
    for (int i = 0; i < 20; i++) do_tick(2'b00, 2'b10, TOP, bwd20[i]);
    do_tick(2'b00, 2'b00, TOP, 15);
    do_tick(2'b00, 2'b10, TOP, 13);
    do_tick(2'b00, 2'b10, TOP, 9);
    do_tick(2'b00, 2'b10, TOP, 3);
    do_tick(2'b00, 2'b00, TOP, 3);
    do_tick(2'b00, 2'b10, TOP, 1);
    do_tick(2'b00, 2'b10, TOP, 0);
    do_tick(2'b00, 2'b10, TOP, 0);

    // Ch0 moving, then reset lands on the same edge as the tick.
    do_tick(2'b00, 2'b01, 277, 0);
    sb.push_back('{p0: 140, p1: 140, mv: 2'b00, amin: 2'b00, amax: 2'b00});
    move_forward  = 2'b00;
    move_backward = 2'b01;
    @(negedge pixel_clock) vertical_sync = 1'b1;
    @(negedge pixel_clock) reset = 1'b1;
    @(negedge pixel_clock) reset = 1'b0;
    repeat (2) @(negedge pixel_clock);
    vertical_sync = 1'b0;
    repeat (3) @(negedge pixel_clock);
    do_tick(2'b01, 2'b00, 142, 140);

    repeat (4) @(negedge pixel_clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
